// File: rtl/countdown_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : countdown_ctrl
//  Purpose  : Sequencer for a cascade of NUM_DIGITS mod-10 down-counter
//             digits forming a countdown timer. Divides clk into count ticks,
//             drives per-digit load/clear/enable with borrow cascading and
//             runs an IDLE/LOADED/RUNNING/PAUSED/DONE state machine from key
//             pulses. done is held for DONE_CYCLES cycles at terminal count.
//  Ports    : clk         - system clock, rising edge
//             clr         - synchronous reset, active-high
//             key_load    - pulse: load preset into digits
//             key_start   - pulse: start / resume countdown
//             key_stop    - pulse: pause countdown
//             key_cancel  - pulse: abort and clear digits
//             cnt_val     - current digit values, digit i at [4i+3:4i]
//             cnt_loadn   - active-low load to all digits (combinational)
//             cnt_clrn    - active-low clear to all digits (combinational)
//             cnt_en      - per-digit count enable (combinational)
//             state       - IDLE=0 LOADED=1 RUNNING=2 PAUSED=3 DONE=4
//             running     - state == RUNNING
//             done        - state == DONE
//  Revision : 1.0 - initial release
// ============================================================================
module countdown_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int TICK_DIV    = 100,
    parameter int DONE_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    key_load,
    input  logic                    key_start,
    input  logic                    key_stop,
    input  logic                    key_cancel,
    input  logic [4*NUM_DIGITS-1:0] cnt_val,
    output logic                    cnt_loadn,
    output logic                    cnt_clrn,
    output logic [NUM_DIGITS-1:0]   cnt_en,
    output logic [2:0]              state,
    output logic                    running,
    output logic                    done
);

    localparam int C_DIV_W  = $clog2(TICK_DIV);
    localparam int C_DONE_W = $clog2(DONE_CYCLES + 1);
    localparam logic [C_DIV_W-1:0]  C_DIV_LAST  = C_DIV_W'(TICK_DIV - 1);
    localparam logic [C_DONE_W-1:0] C_DONE_LAST = C_DONE_W'(DONE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOADED  = 3'd1,
        S_RUNNING = 3'd2,
        S_PAUSED  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                state_q,    state_d;
    logic [C_DIV_W-1:0]    div_q,      div_d;
    logic [C_DONE_W-1:0]   done_cnt_q, done_cnt_d;

    logic [NUM_DIGITS-1:0] w_digit_zero;
    logic [NUM_DIGITS-1:0] w_lower_zero;
    logic                  w_all_zero;
    logic                  w_tick;
    logic                  w_abort;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit_zero
            assign w_digit_zero[gi] = (cnt_val[4*gi +: 4] == 4'd0);
        end
    endgenerate

    // Borrow cascade: digit i may decrement only when every lower digit is
    // zero (it is about to wrap 0 -> 9 and borrow from digit i).
    always_comb begin
        w_lower_zero    = '0;
        w_lower_zero[0] = 1'b1;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            w_lower_zero[i] = w_lower_zero[i-1] & w_digit_zero[i-1];
        end
    end

    assign w_all_zero = &w_digit_zero;
    assign w_tick     = (div_q == C_DIV_LAST);

    // Cancel aborts from every state except IDLE, where it only acts when it
    // coincides with a load (clear wins over load).
    assign w_abort = key_cancel & (key_load | (state_q != S_IDLE));

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        done_cnt_d = done_cnt_q;
        cnt_loadn  = 1'b1;
        cnt_clrn   = 1'b1;
        cnt_en     = '0;

        if (clr) begin
            cnt_clrn   = 1'b0;
            state_d    = S_IDLE;
            div_d      = '0;
            done_cnt_d = '0;
        end else if (w_abort) begin
            cnt_clrn = 1'b0;
            state_d  = S_IDLE;
        end else if (key_load) begin
            cnt_loadn = 1'b0;
            state_d   = S_LOADED;
        end else begin
            case (state_q)
                S_LOADED: begin
                    if (key_start && !w_all_zero) begin
                        state_d = S_RUNNING;
                        div_d   = '0;
                    end
                end
                S_RUNNING: begin
                    if (w_all_zero) begin
                        state_d    = S_DONE;
                        done_cnt_d = '0;
                    end else begin
                        // A stop still lets this cycle count; the pause
                        // takes effect from the next cycle.
                        div_d = w_tick ? '0 : div_q + C_DIV_W'(1);
                        if (w_tick) begin
                            cnt_en = w_lower_zero;
                        end
                        if (key_stop) begin
                            state_d = S_PAUSED;
                        end
                    end
                end
                S_PAUSED: begin
                    // Divider holds, so a resume keeps the tick phase.
                    if (key_start) begin
                        state_d = S_RUNNING;
                    end
                end
                S_DONE: begin
                    if (done_cnt_q == C_DONE_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        done_cnt_d = done_cnt_q + C_DONE_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            done_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    assign state   = state_q;
    assign running = (state_q == S_RUNNING);
    assign done    = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_countdown_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_countdown_ctrl
//  Purpose  : Self-checking bench for countdown_ctrl. Models the digit cascade
//             as an integer count value and predicts every output each cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_countdown_ctrl;

    localparam int ND = 2;
    localparam int TD = 4;
    localparam int DC = 3;

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic          key_load = 1'b0, key_start = 1'b0, key_stop = 1'b0, key_cancel = 1'b0;
    logic [4*ND-1:0] cnt_val = '0;
    logic [4*ND-1:0] preset = '0;
    logic          cnt_loadn, cnt_clrn;
    logic [ND-1:0] cnt_en;
    logic [2:0]    state;
    logic          running, done;

    int checks = 0;
    int errors = 0;

    countdown_ctrl #(.NUM_DIGITS(ND), .TICK_DIV(TD), .DONE_CYCLES(DC)) dut (
        .clk(clk), .clr(clr), .key_load(key_load), .key_start(key_start),
        .key_stop(key_stop), .key_cancel(key_cancel), .cnt_val(cnt_val),
        .cnt_loadn(cnt_loadn), .cnt_clrn(cnt_clrn), .cnt_en(cnt_en),
        .state(state), .running(running), .done(done)
    );

    always #5 clk = ~clk;

    // ---------------- digit cascade environment ----------------
    always @(posedge clk) begin
        if (!cnt_clrn) begin
            cnt_val <= '0;
        end else if (!cnt_loadn) begin
            cnt_val <= preset;
        end else begin
            for (int i = 0; i < ND; i++) begin
                if (cnt_en[i]) begin
                    cnt_val[4*i +: 4] <= (cnt_val[4*i +: 4] == 4'd0) ? 4'd9 : cnt_val[4*i +: 4] - 4'd1;
                end
            end
        end
    end

    function automatic int bcd2int(input logic [4*ND-1:0] v);
        int r = 0;
        for (int i = ND - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [4*ND-1:0] int2bcd(input int v);
        logic [4*ND-1:0] r = '0;
        int x = v;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Modes: 0 idle, 1 loaded, 2 running, 3 paused, 4 done. The count is a
    // plain integer; a tick subtracts one, and the digits whose value changes
    // under that subtraction are exactly those that must be enabled.
    int m_state = 0, m_div = 0, m_done = 0, m_val = 0, m_valid = 0;
    int n_state = 0, n_div = 0, n_done = 0, n_val = 0;
    logic          e_clrn, e_loadn;
    logic [ND-1:0] e_en;

    task automatic model_eval();
        int p;
        e_clrn = 1'b1; e_loadn = 1'b1; e_en = '0;
        n_state = m_state; n_div = m_div; n_done = m_done; n_val = m_val;
        if (clr) begin
            e_clrn = 1'b0; n_state = 0; n_div = 0; n_done = 0; n_val = 0;
        end else if (key_cancel && (key_load || m_state != 0)) begin
            e_clrn = 1'b0; n_state = 0; n_val = 0;
        end else if (key_load) begin
            e_loadn = 1'b0; n_state = 1; n_val = bcd2int(preset);
        end else if (m_state == 1) begin
            if (key_start && m_val != 0) begin n_state = 2; n_div = 0; end
        end else if (m_state == 2) begin
            if (m_val == 0) begin
                n_state = 4; n_done = 0;
            end else begin
                if (m_div == TD - 1) begin
                    p = 1;
                    for (int i = 0; i < ND; i++) begin
                        e_en[i] = (m_val % p == 0);
                        p = p * 10;
                    end
                    n_val = m_val - 1;
                end
                n_div = (m_div + 1) % TD;
                if (key_stop) n_state = 3;
            end
        end else if (m_state == 3) begin
            if (key_start) n_state = 2;
        end else if (m_state == 4) begin
            if (m_done == DC - 1) n_state = 0;
            else n_done = m_done + 1;
        end
    endtask

    always @(negedge clk) begin
        model_eval();
        if (m_valid != 0) begin
            chk("cnt_clrn",  int'(cnt_clrn),  int'(e_clrn));
            chk("cnt_loadn", int'(cnt_loadn), int'(e_loadn));
            chk("cnt_en",    int'(cnt_en),    int'(e_en));
            chk("state",     int'(state),     m_state);
            chk("running",   int'(running),   int'(m_state == 2));
            chk("done",      int'(done),      int'(m_state == 4));
            chk("cnt_val",   int'(cnt_val),   int'(int2bcd(m_val)));
        end
    end

    always @(posedge clk) begin
        m_state <= n_state; m_div <= n_div; m_done <= n_done; m_val <= n_val;
        if (clr) m_valid <= 1;
    end

    // ---------------- directed helpers ----------------
    int ob_st[5];
    int ob_en_any, ob_en_both;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load(input logic [4*ND-1:0] v);
        preset = v; key_load = 1'b1; step(); key_load = 1'b0;
    endtask

    task automatic pulse_start();
        key_start = 1'b1; step(); key_start = 1'b0;
    endtask

    task automatic observe(input int n);
        for (int i = 0; i < 5; i++) ob_st[i] = 0;
        ob_en_any = 0; ob_en_both = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (state < 3'd5) ob_st[state] = ob_st[state] + 1;
            if (cnt_en != '0) ob_en_any++;
            if (cnt_en == 2'b11) ob_en_both++;
            step();
        end
    endtask

    initial begin
        repeat (3) step();
        @(negedge clk);
        chk("reset_clrn", int'(cnt_clrn), 0);
        chk("reset_en", int'(cnt_en), 0);
        chk("reset_state", int'(state), 0);
        step();
        clr = 1'b0;

        // Count 12 down at one tick per 4 cycles.
        pulse_load(8'h12);
        pulse_start();
        observe(60);
        chk("t1_running_cycles", ob_st[2], 49);
        chk("t1_ticks", ob_en_any, 12);
        chk("t1_borrow_ticks", ob_en_both, 1);
        chk("t1_done_cycles", ob_st[4], DC);
        chk("t1_end_state", int'(state), 0);

        // Pause with divider at 2, resume keeps phase.
        pulse_load(8'h12);
        pulse_start();
        step(); step();
        key_stop = 1'b1; step(); key_stop = 1'b0;
        observe(20);
        chk("t2_paused_cycles", ob_st[3], 20);
        chk("t2_paused_ticks", ob_en_any, 0);
        key_start = 1'b1;
        @(negedge clk);
        chk("t2_start_cycle_en", int'(cnt_en), 0);
        step(); key_start = 1'b0;
        @(negedge clk);
        chk("t2_resume_tick", int'(cnt_en), 1);

        // Cancel while running.
        step();
        key_cancel = 1'b1;
        @(negedge clk);
        chk("t3_clrn_low", int'(cnt_clrn), 0);
        step(); key_cancel = 1'b0;
        @(negedge clk);
        chk("t3_clrn_released", int'(cnt_clrn), 1);
        chk("t3_state", int'(state), 0);
        chk("t3_val", int'(cnt_val), 0);
        step();

        // Start with a zero preset is ignored.
        pulse_load(8'h00);
        pulse_start();
        observe(10);
        chk("t4_loaded_cycles", ob_st[1], 10);
        chk("t4_no_enable", ob_en_any, 0);

        // clr mid-run.
        pulse_load(8'h12);
        pulse_start();
        repeat (5) step();
        clr = 1'b1;
        @(negedge clk);
        chk("t5_clrn", int'(cnt_clrn), 0);
        chk("t5_en", int'(cnt_en), 0);
        step(); clr = 1'b0;
        @(negedge clk);
        chk("t5_state", int'(state), 0);
        chk("t5_done", int'(done), 0);
        step();

        // Stop and cancel together.
        pulse_load(8'h05);
        pulse_start();
        step(); step();
        key_stop = 1'b1; key_cancel = 1'b1;
        @(negedge clk);
        chk("t6_clrn", int'(cnt_clrn), 0);
        step(); key_stop = 1'b0; key_cancel = 1'b0;
        @(negedge clk);
        chk("t6_state", int'(state), 0);
        chk("t6_val", int'(cnt_val), 0);
        step();

        // Stop on the cycle zero is first seen: terminal count wins.
        pulse_load(8'h01);
        pulse_start();
        repeat (4) step();
        key_stop = 1'b1;
        @(negedge clk);
        chk("t6b_no_enable", int'(cnt_en), 0);
        step(); key_stop = 1'b0;
        @(negedge clk);
        chk("t6b_state", int'(state), 4);
        chk("t6b_done", int'(done), 1);
        step();

        // Random key traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            key_load   = ($urandom_range(0, 39) == 0);
            key_start  = ($urandom_range(0, 9) == 0);
            key_stop   = ($urandom_range(0, 29) == 0);
            key_cancel = ($urandom_range(0, 79) == 0);
            clr        = ($urandom_range(0, 399) == 0);
            preset     = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
            step();
        end
        key_load = 1'b0; key_start = 1'b0; key_stop = 1'b0; key_cancel = 1'b0; clr = 1'b0;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
